// File: rtl/mmio_ctrl.sv
// MMIO controller: seven-segment regs, UART TX FIFO, status.
// Optional 64-bit cycle counter under MMIO_CYCLE_COUNTER_EN.
package microcode;
  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] MEM_WE_MASK = 8'h02;

  function automatic logic mcs2_mem_we(
    input logic [WIDTH-1:0] mc
  );
    return (mc & MEM_WE_MASK) != '0;
  endfunction
endpackage

module mmio_ctrl #(
  parameter int MMIO_ADDR_START_BIT = 16,
  parameter int NUM_SEG = 2,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_enable,
  input  logic [microcode::WIDTH-1:0]   microcode_s2,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   data_in,
  output logic [31:0]                   data_out,
  output logic                          is_mmio,
  output logic [16*NUM_SEG-1:0]         seven_segment_out,
  output logic [7:0]                    uart_tx_data,
  output logic                          uart_tx_valid,
  input  logic                          uart_tx_ready
);
  import microcode::*;

  localparam int OW = MMIO_ADDR_START_BIT;
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = TX_FIFO_DEPTH[PW:0];
  localparam logic [OW-1:0] OFF_TX = OW'('h40);
  localparam logic [OW-1:0] OFF_ST = OW'('h44);
`ifdef MMIO_CYCLE_COUNTER_EN
  localparam logic [OW-1:0] OFF_LO = OW'('h48);
  localparam logic [OW-1:0] OFF_HI = OW'('h4C);
`endif

  logic [OW-1:0] off;
  logic          acc;
  logic          wr_en;
  logic [31:0]   rdata;
  wire           unused = ^{addr, data_in};

  assign is_mmio = addr[OW];
  assign off     = addr[OW-1:0];
  assign acc     = clk_enable & is_mmio;
  assign wr_en   = acc & mcs2_mem_we(microcode_s2);

  // Seven-segment registers hold the inverted (active-low) pattern
  logic [15:0]        seg_q [NUM_SEG];
  logic [NUM_SEG-1:0] seg_sel;

  always_comb begin
    seg_sel = '0;
    for (int i = 0; i < NUM_SEG; i++)
      seg_sel[i] = (off == OW'(4 * i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++)
        seg_q[i] <= '1;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SEG; i++)
        if (seg_sel[i]) seg_q[i] <= ~data_in[15:0];
    end
  end

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_seg
    assign seven_segment_out[16*g +: 16] = seg_q[g];
  end

  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [7:0]    last_tx;
  logic          overflow;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          ovf_set;
  logic          ovf_clr;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop      = uart_tx_valid & uart_tx_ready;
  assign push_req = wr_en & (off == OFF_TX);
  // A full FIFO still accepts a byte when the head leaves this edge
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = wr_en & (off == OFF_ST) & data_in[2];

  assign uart_tx_valid = ~empty;
  assign uart_tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_tx  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (push_req) last_tx <= data_in[7:0];
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [63:0] cyc;
  logic [31:0] cyc_snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc      <= '0;
      cyc_snap <= '0;
    end else begin
      cyc <= cyc + 64'd1;
      // LO read freezes HI so a LO/HI pair never tears on carry
      if (acc && off == OFF_LO) cyc_snap <= cyc[63:32];
    end
  end
`endif

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_SEG; i++)
      if (seg_sel[i]) rdata = {16'h0, ~seg_q[i]};
    if (off == OFF_TX)
      rdata = {24'h0, last_tx};
    if (off == OFF_ST)
      rdata = {16'h0, 8'(count), 5'h0, overflow, full, empty};
`ifdef MMIO_CYCLE_COUNTER_EN
    if (off == OFF_LO) rdata = cyc[31:0];
    if (off == OFF_HI) rdata = cyc_snap;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      data_out <= '0;
    else if (acc) data_out <= rdata;
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed steps plus random
// traffic compared against a queue-based reference model.
module tb_mmio_ctrl;
  localparam int SB = 16;
  localparam int NS = 2;
  localparam int DEPTH = 8;

  logic        clk = 0;
  logic        rst;
  logic        clk_enable;
  logic [7:0]  microcode_s2;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        is_mmio;
  logic [16*NS-1:0] seven_segment_out;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  mmio_ctrl #(
    .MMIO_ADDR_START_BIT(SB),
    .NUM_SEG(NS),
    .TX_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_enable(clk_enable),
    .microcode_s2(microcode_s2),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .is_mmio(is_mmio),
    .seven_segment_out(seven_segment_out),
    .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [15:0] m_seg [NS];
  logic [7:0]  m_q [$];
  logic [7:0]  m_last;
  bit          m_ovf;
  logic [31:0] m_dout;
  logic [63:0] m_cyc;
  logic [31:0] m_snap;
  bit          m_we;

  always @(posedge clk or posedge rst)
    if (rst) m_cyc <= 0;
    else     m_cyc <= m_cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] off);
    logic [31:0] r;
    r = 0;
    if (off < 16'(4 * NS) && off[1:0] == 0)
      r = {16'h0, m_seg[off[4:2]]};
    else if (off == 16'h40)
      r = {24'h0, m_last};
    else if (off == 16'h44)
      r = {16'h0, 8'(m_q.size()), 5'h0, m_ovf,
           m_q.size() == DEPTH, m_q.size() == 0};
`ifdef MMIO_CYCLE_COUNTER_EN
    else if (off == 16'h48) r = m_cyc[31:0];
    else if (off == 16'h4C) r = m_snap;
`endif
    return r;
  endfunction

  function automatic logic [16*NS-1:0] m_segs();
    logic [16*NS-1:0] v;
    for (int i = 0; i < NS; i++) v[16*i +: 16] = ~m_seg[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_seg[i] = 0;
    m_q.delete();
    m_last = 0;
    m_ovf = 0;
    m_dout = 0;
    m_snap = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"}, 64'(data_out), 64'(m_dout));
    chk({tag, ".seg"}, 64'(seven_segment_out), 64'(m_segs()));
    chk({tag, ".valid"}, 64'(uart_tx_valid), 64'(m_q.size() != 0));
    chk({tag, ".txd"}, 64'(uart_tx_data),
        64'(m_q.size() != 0 ? m_q[0] : 8'h00));
  endtask

  // One clock with the inputs currently driven; model advances alongside
  task automatic step(input string tag);
    bit acc;
    bit pop;
    bit full;
    logic [15:0] off;
    logic [31:0] rd;
    acc  = clk_enable && addr[SB];
    off  = addr[15:0];
    rd   = m_read(off);
    pop  = m_q.size() != 0 && uart_tx_ready;
    full = m_q.size() == DEPTH;
`ifdef MMIO_CYCLE_COUNTER_EN
    if (acc && off == 16'h48) m_snap = m_cyc[63:32];
`endif
    if (pop) void'(m_q.pop_front());
    if (acc && m_we) begin
      if (off < 16'(4 * NS) && off[1:0] == 0)
        m_seg[off[4:2]] = data_in[15:0];
      else if (off == 16'h40) begin
        m_last = data_in[7:0];
        if (!full || pop) m_q.push_back(data_in[7:0]);
        else m_ovf = 1;
      end else if (off == 16'h44 && data_in[2])
        m_ovf = 0;
    end
    if (acc) m_dout = rd;
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input bit en, input bit mm, input bit we,
                       input logic [15:0] off, input logic [31:0] d);
    logic [7:0] mc;
    mc = 8'($urandom) & ~microcode::MEM_WE_MASK;
    if (we) mc = mc | microcode::MEM_WE_MASK;
    clk_enable   = en;
    microcode_s2 = mc;
    m_we         = we;
    addr         = {15'($urandom), mm, off};
    data_in      = d;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic bus(input string tag, input bit we,
                     input logic [15:0] off, input logic [31:0] d);
    drive(1'b1, 1'b1, we, off, d);
    step(tag);
    idle();
  endtask

  logic [15:0] offs [8];

  initial begin
    offs = '{16'h0, 16'h4, 16'h8, 16'h40, 16'h44, 16'h48, 16'h4C, 16'h1};
    rst = 1;
    uart_tx_ready = 0;
    idle();
    m_reset();
    #12;
    chk("reset.valid_async", 64'(uart_tx_valid), 64'h0);
    @(negedge clk);
    rst = 0;
    check_all("reset");
    chk("reset.seg_blank", 64'(seven_segment_out), 64'hFFFF_FFFF);

    bus("rd_seg0", 0, 16'h0, 0);
    chk("seg0_val", 64'(data_out), 64'h0);
    bus("rd_stat", 0, 16'h44, 0);
    chk("stat_reset", 64'(data_out), 64'h1);

    drive(1'b1, 1'b1, 1'b0, 16'h0, 0);
    chk("is_mmio_hi", 64'(is_mmio), 64'h1);
    idle();
    chk("is_mmio_lo", 64'(is_mmio), 64'h0);

    bus("wr_seg1", 1, 16'h4, 32'hFFFF_1234);
    chk("seg1_out", 64'(seven_segment_out[31:16]), 64'hEDCB);
    chk("seg0_keep", 64'(seven_segment_out[15:0]), 64'hFFFF);
    bus("rd_seg1", 0, 16'h4, 0);
    chk("seg1_rd", 64'(data_out), 64'h1234);
    bus("rd_08", 0, 16'h8, 0);
    chk("off08_rd", 64'(data_out), 64'h0);

    for (int i = 1; i <= 9; i++)
      bus("push", 1, 16'h40, 32'(i));
    bus("rd_stat", 0, 16'h44, 0);
    chk("stat_ovf", 64'(data_out), 64'h806);
    uart_tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_byte", 64'(uart_tx_data), 64'(i));
      step("drain");
    end
    chk("drain_empty", 64'(uart_tx_valid), 64'h0);
    uart_tx_ready = 0;
    bus("clr_ovf", 1, 16'h44, 32'h4);
    bus("rd_stat", 0, 16'h44, 0);
    chk("stat_clr", 64'(data_out), 64'h1);

    for (int i = 0; i < 8; i++)
      bus("fill", 1, 16'h40, 32'($urandom));
    uart_tx_ready = 1;
    bus("push_pop", 1, 16'h40, 32'hAA);
    uart_tx_ready = 0;
    bus("rd_stat", 0, 16'h44, 0);
    chk("stat_pushpop", 64'(data_out), 64'h802);
    uart_tx_ready = 1;
    for (int i = 0; i < 7; i++) step("drain2");
    chk("last_aa", 64'(uart_tx_data), 64'hAA);
    step("drain2_end");
    chk("drain2_empty", 64'(uart_tx_valid), 64'h0);

    uart_tx_ready = 0;
    for (int i = 0; i < 3; i++)
      bus("fill3", 1, 16'h40, 32'(8'h50 + i));
    bus("rd_seg1b", 0, 16'h4, 0);
    uart_tx_ready = 1;
    drive(1'b0, 1'b1, 1'b1, 16'h0, 32'h0000_5A5A);
    step("ce0_a");
    step("ce0_b");
    chk("ce0_dout_hold", 64'(data_out), 64'h1234);
    chk("ce0_seg0", 64'(seven_segment_out[15:0]), 64'hFFFF);
    step("ce0_c");
    chk("ce0_drained", 64'(uart_tx_valid), 64'h0);
    idle();

    bus("rd_lo", 0, 16'h48, 0);
    step("gap");
    step("gap");
    bus("rd_hi", 0, 16'h4C, 0);
`ifndef MMIO_CYCLE_COUNTER_EN
    chk("cyc_hi_zero", 64'(data_out), 64'h0);
`endif

    uart_tx_ready = 0;
    for (int i = 0; i < 4; i++)
      bus("fill_rst", 1, 16'h40, 32'($urandom));
    uart_tx_ready = 1;
    #2 rst = 1;
    m_reset();
    #1;
    chk("rst_drain_valid", 64'(uart_tx_valid), 64'h0);
    chk("rst_drain_data", 64'(uart_tx_data), 64'h0);
    @(negedge clk);
    rst = 0;
    check_all("after_rst");

    for (int n = 0; n < 400; n++) begin
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 1) == 1, offs[$urandom_range(0, 7)],
            ($urandom_range(0, 3) == 0) ? 32'h4 : $urandom);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
